// File: rtl/mapper_ctx_engine_pkg.sv
// Shared definitions for the mapper context save/restore engine.
package mapper_ctx_engine_pkg;

  // Mapper register indices, also used by the mapper FSM and hypervisor decode.
  localparam logic [1:0] MAPREG_A = 2'd3;
  localparam logic [1:0] MAPREG_X = 2'd2;
  localparam logic [1:0] MAPREG_Y = 2'd1;
  localparam logic [1:0] MAPREG_Z = 2'd0;

  typedef enum logic [1:0] {
    CTX_IDLE   = 2'd0,
    CTX_SAVE   = 2'd1,
    CTX_RST_WR = 2'd2,
    CTX_FINISH = 2'd3
  } ctx_state_e;

endpackage

// File: rtl/mapper_ctx_shadow.sv
// 4x8 shadow register file: engine capture port wins over hypervisor writes,
// which are only honoured while the engine is idle.
module mapper_ctx_shadow
  import mapper_ctx_engine_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       busy,
  input  logic       cap_en,
  input  logic [1:0] eng_idx,
  input  logic [7:0] cap_data,
  input  logic [1:0] hyp_idx,
  input  logic       hyp_we,
  input  logic [7:0] hyp_wdata,
  output logic [7:0] eng_rdata,
  output logic [7:0] hyp_rdata
);

  logic [7:0] mem [4];

  // Single write port with engine capture taking priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (cap_en) begin
      mem[eng_idx] <= cap_data;
    end else if (hyp_we && !busy) begin
      mem[hyp_idx] <= hyp_wdata;
    end
  end

  assign eng_rdata = mem[eng_idx];
  assign hyp_rdata = mem[hyp_idx];

endmodule

// File: rtl/mapper_ctx_engine.sv
// Save/restore engine for the user mapper registers A, X, Y, Z.
//
// state      | meaning
// -----------+----------------------------------------------------------
// CTX_IDLE   | waiting for save_req / restore_req
// CTX_SAVE   | reading mapper reg idx into shadow, one per cycle (A..Z)
// CTX_RST_WR | writing shadow[idx] to mapper; holds while map_active
// CTX_FINISH | one-cycle done pulse; marks shadow valid after a save
module mapper_ctx_engine
  import mapper_ctx_engine_pkg::*;
#(
  parameter int unsigned STALL_MAX = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       save_req,
  input  logic       restore_req,
  output logic       busy,
  output logic       done,
  output logic       abort,
  output logic       shadow_valid,
  output logic [1:0] map_reg_sel,
  input  logic [7:0] map_reg_data,
  output logic [1:0] map_reg_write_sel,
  output logic [7:0] map_reg_wdata,
  output logic       hypervisor_load_user_reg,
  input  logic       map_active,
  output logic       sel_override,
  input  logic [1:0] shadow_idx,
  input  logic       shadow_we,
  input  logic [7:0] shadow_wdata,
  output logic [7:0] shadow_rdata
);

  // Stall timer counts down to zero; the stall seen at zero is the STALL_MAX-th.
  localparam logic [15:0] STALL_LOAD = 16'(STALL_MAX - 1);

  ctx_state_e  state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        op_save, op_save_nxt;
  logic [15:0] stall_cnt, stall_cnt_nxt;
  logic        cap_en;
  logic [7:0]  eng_rdata;

  mapper_ctx_shadow u_shadow (
    .clk       (clk),
    .reset_n   (reset_n),
    .busy      (busy),
    .cap_en    (cap_en),
    .eng_idx   (idx),
    .cap_data  (map_reg_data),
    .hyp_idx   (shadow_idx),
    .hyp_we    (shadow_we),
    .hyp_wdata (shadow_wdata),
    .eng_rdata (eng_rdata),
    .hyp_rdata (shadow_rdata)
  );

  assign busy = (state != CTX_IDLE);

  // State, index, operation kind and stall timer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CTX_IDLE;
      idx       <= MAPREG_A;
      op_save   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      op_save   <= op_save_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  // Shadow contents become valid once a save has fully completed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_valid <= 1'b0;
    end else if (state == CTX_FINISH && op_save) begin
      shadow_valid <= 1'b1;
    end
  end

  // Next-state and combinational outputs; the write strobe is unregistered
  // so the mapper sees it in the same cycle it is decided.
  always_comb begin
    state_nxt                = state;
    idx_nxt                  = idx;
    op_save_nxt              = op_save;
    stall_cnt_nxt            = stall_cnt;
    done                     = 1'b0;
    abort                    = 1'b0;
    cap_en                   = 1'b0;
    sel_override             = 1'b0;
    map_reg_sel              = MAPREG_A;
    map_reg_write_sel        = 2'd0;
    map_reg_wdata            = 8'h00;
    hypervisor_load_user_reg = 1'b0;
    case (state)
      CTX_IDLE: begin
        if (save_req) begin
          state_nxt   = CTX_SAVE;
          idx_nxt     = MAPREG_A;
          op_save_nxt = 1'b1;
        end else if (restore_req) begin
          state_nxt     = CTX_RST_WR;
          idx_nxt       = MAPREG_A;
          op_save_nxt   = 1'b0;
          stall_cnt_nxt = STALL_LOAD;
        end
      end
      CTX_SAVE: begin
        sel_override = 1'b1;
        map_reg_sel  = idx;
        cap_en       = 1'b1;
        idx_nxt      = idx - 2'd1;
        if (idx == MAPREG_Z) state_nxt = CTX_FINISH;
      end
      CTX_RST_WR: begin
        if (!map_active) begin
          hypervisor_load_user_reg = 1'b1;
          map_reg_write_sel        = idx;
          map_reg_wdata            = eng_rdata;
          stall_cnt_nxt            = STALL_LOAD;
          idx_nxt                  = idx - 2'd1;
          if (idx == MAPREG_Z) state_nxt = CTX_FINISH;
        end else if (stall_cnt == 16'd0) begin
          abort     = 1'b1;
          state_nxt = CTX_IDLE;
        end else begin
          stall_cnt_nxt = stall_cnt - 16'd1;
        end
      end
      CTX_FINISH: begin
        done      = 1'b1;
        state_nxt = CTX_IDLE;
      end
      default: state_nxt = CTX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mapper_ctx_engine.sv
// Bench for mapper_ctx_engine: vector table, reset corner case, random ops
// against a queue-based reference model of the save/restore behaviour.
module tb_mapper_ctx_engine;

  localparam int STALL_MAX = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       save_req, restore_req;
  logic       busy, done, abort, shadow_valid;
  logic [1:0] map_reg_sel;
  logic [7:0] map_reg_data;
  logic [1:0] map_reg_write_sel;
  logic [7:0] map_reg_wdata;
  logic       hypervisor_load_user_reg;
  logic       map_active;
  logic       sel_override;
  logic [1:0] shadow_idx;
  logic       shadow_we;
  logic [7:0] shadow_wdata;
  logic [7:0] shadow_rdata;

  // Mapper register model (driven by DUT writes) and reference model state.
  logic [7:0] mreg [4];
  logic [7:0] mexp [4];
  logic [7:0] sh_m [4];
  bit         sv_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign map_reg_data = mreg[map_reg_sel];

  mapper_ctx_engine #(.STALL_MAX(STALL_MAX)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .save_req                 (save_req),
    .restore_req              (restore_req),
    .busy                     (busy),
    .done                     (done),
    .abort                    (abort),
    .shadow_valid             (shadow_valid),
    .map_reg_sel              (map_reg_sel),
    .map_reg_data             (map_reg_data),
    .map_reg_write_sel        (map_reg_write_sel),
    .map_reg_wdata            (map_reg_wdata),
    .hypervisor_load_user_reg (hypervisor_load_user_reg),
    .map_active               (map_active),
    .sel_override             (sel_override),
    .shadow_idx               (shadow_idx),
    .shadow_we                (shadow_we),
    .shadow_wdata             (shadow_wdata),
    .shadow_rdata             (shadow_rdata)
  );

  typedef struct {
    bit          do_save;
    bit          do_rest;
    logic [31:0] mvals;
    bit          hyp_wr;
    logic [1:0]  hyp_idx;
    logic [7:0]  hyp_data;
    int          st_start;
    int          st_len;
    int          inj_c;
    int          exp_end;
    bit          exp_abort;
    logic [31:0] exp_shadow;
    logic [31:0] exp_mapper;
  } vec_t;

  vec_t vecs [6];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_mapper(input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      mreg[i] = v[i*8 +: 8];
      mexp[i] = v[i*8 +: 8];
    end
  endtask

  task automatic hyp_write(input logic [1:0] i, input logic [7:0] d);
    shadow_we = 1'b1; shadow_idx = i; shadow_wdata = d;
    @(posedge clk); #1;
    shadow_we = 1'b0;
    sh_m[i] = d;
  endtask

  task automatic read_shadow(output logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      shadow_idx = 2'(i); #1;
      v[i*8 +: 8] = shadow_rdata;
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] rd;
    read_shadow(rd);
    check({tag, "_shadow"}, rd, {sh_m[3], sh_m[2], sh_m[1], sh_m[0]});
    check({tag, "_valid"}, shadow_valid, sv_m);
    check({tag, "_mapper"}, {mreg[3], mreg[2], mreg[1], mreg[0]},
          {mexp[3], mexp[2], mexp[1], mexp[0]});
  endtask

  // Issue one request and check every cycle against the reference model.
  // dut_end is the cycle (1 = first after acceptance) where DUT pulsed done/abort.
  task automatic run_op(input bit rq_save, input bit rq_rest, input int st_start,
                        input int st_len, input int inj_c,
                        output int dut_end, output bit dut_abort);
    int         q_idx [$];
    logic [7:0] q_dat [$];
    bit         is_save, fin;
    int         consec;
    is_save = rq_save;
    for (int i = 3; i >= 0; i--) begin
      q_idx.push_back(i);
      q_dat.push_back(sh_m[i]);
    end
    consec = 0; fin = 1'b0; dut_end = -1; dut_abort = 1'b0;
    save_req = rq_save; restore_req = rq_rest;
    @(posedge clk); #1;
    save_req = 1'b0; restore_req = 1'b0;
    for (int c = 1; c <= 40 && !fin; c++) begin
      map_active = (c >= st_start && c < st_start + st_len);
      if (c == inj_c) begin
        restore_req = 1'b1; shadow_we = 1'b1; shadow_idx = 2'd1; shadow_wdata = 8'hEE;
      end
      @(negedge clk);
      if ((done || abort) && dut_end < 0) dut_end = c;
      if (abort) dut_abort = 1'b1;
      check("busy_during_op", busy, 1);
      if (q_idx.size() > 0) begin
        if (is_save) begin
          check("save_override", sel_override, 1);
          check("save_rd_sel", map_reg_sel, q_idx[0]);
          check("save_no_strobe", hypervisor_load_user_reg, 0);
          sh_m[q_idx[0]] = mreg[q_idx[0]];
          void'(q_idx.pop_front());
          check("save_no_done", done, 0);
        end else if (map_active) begin
          consec++;
          check("stall_no_strobe", hypervisor_load_user_reg, 0);
          if (consec == STALL_MAX) begin
            check("stall_abort", abort, 1);
            fin = 1'b1;
          end else begin
            check("stall_no_abort", abort, 0);
          end
          check("stall_no_done", done, 0);
        end else begin
          consec = 0;
          check("wr_strobe", hypervisor_load_user_reg, 1);
          check("wr_sel", map_reg_write_sel, q_idx[0]);
          check("wr_data", map_reg_wdata, q_dat[0]);
          check("wr_no_abort", abort, 0);
          mexp[q_idx[0]] = q_dat[0];
          void'(q_idx.pop_front());
          void'(q_dat.pop_front());
        end
      end else begin
        check("finish_done", done, 1);
        check("finish_no_strobe", hypervisor_load_user_reg, 0);
        if (is_save) sv_m = 1'b1;
        fin = 1'b1;
      end
      if (hypervisor_load_user_reg) mreg[map_reg_write_sel] = map_reg_wdata;
      @(posedge clk); #1;
      restore_req = 1'b0; shadow_we = 1'b0;
    end
    map_active = 1'b0;
    if (!fin) check("op_timeout", 0, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_strobe", hypervisor_load_user_reg, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    int          e;
    bit          ab;

    vecs[0] = '{do_save:1, do_rest:0, mvals:32'h4031003F, hyp_wr:0, hyp_idx:0, hyp_data:0,
                st_start:0, st_len:0, inj_c:0, exp_end:5, exp_abort:0,
                exp_shadow:32'h4031003F, exp_mapper:32'h4031003F};
    vecs[1] = '{do_save:0, do_rest:1, mvals:32'h00000000, hyp_wr:1, hyp_idx:2, hyp_data:8'h8A,
                st_start:0, st_len:0, inj_c:0, exp_end:5, exp_abort:0,
                exp_shadow:32'h408A003F, exp_mapper:32'h408A003F};
    vecs[2] = '{do_save:0, do_rest:1, mvals:32'h11223344, hyp_wr:0, hyp_idx:0, hyp_data:0,
                st_start:2, st_len:3, inj_c:0, exp_end:8, exp_abort:0,
                exp_shadow:32'h408A003F, exp_mapper:32'h408A003F};
    vecs[3] = '{do_save:0, do_rest:1, mvals:32'h11223344, hyp_wr:0, hyp_idx:0, hyp_data:0,
                st_start:1, st_len:10, inj_c:0, exp_end:4, exp_abort:1,
                exp_shadow:32'h408A003F, exp_mapper:32'h11223344};
    vecs[4] = '{do_save:1, do_rest:1, mvals:32'hAA5501FE, hyp_wr:0, hyp_idx:0, hyp_data:0,
                st_start:0, st_len:0, inj_c:4, exp_end:5, exp_abort:0,
                exp_shadow:32'hAA5501FE, exp_mapper:32'hAA5501FE};
    vecs[5] = '{do_save:0, do_rest:1, mvals:32'h00000000, hyp_wr:0, hyp_idx:0, hyp_data:0,
                st_start:3, st_len:8, inj_c:0, exp_end:6, exp_abort:1,
                exp_shadow:32'hAA5501FE, exp_mapper:32'hAA550000};

    reset_n = 1'b0; save_req = 1'b0; restore_req = 1'b0; map_active = 1'b0;
    shadow_idx = 2'd0; shadow_we = 1'b0; shadow_wdata = 8'h00;
    set_mapper(32'h0);
    for (int i = 0; i < 4; i++) sh_m[i] = 8'h00;
    sv_m = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_abort", abort, 0);
    check("rst_valid", shadow_valid, 0);
    check("rst_rd_sel", map_reg_sel, 3);
    check("rst_override", sel_override, 0);
    check("rst_strobe", hypervisor_load_user_reg, 0);
    check("rst_wr_sel", map_reg_write_sel, 0);
    check("rst_wdata", map_reg_wdata, 0);
    read_shadow(rd);
    check("rst_shadow", rd, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Vector table.
    for (int v = 0; v < 6; v++) begin
      set_mapper(vecs[v].mvals);
      if (vecs[v].hyp_wr) hyp_write(vecs[v].hyp_idx, vecs[v].hyp_data);
      run_op(vecs[v].do_save, vecs[v].do_rest, vecs[v].st_start, vecs[v].st_len,
             vecs[v].inj_c, e, ab);
      check("tbl_end_cycle", e, vecs[v].exp_end);
      check("tbl_abort", ab, vecs[v].exp_abort);
      read_shadow(rd);
      check("tbl_shadow", rd, vecs[v].exp_shadow);
      check("tbl_mapper", {mreg[3], mreg[2], mreg[1], mreg[0]}, vecs[v].exp_mapper);
      check("tbl_valid", shadow_valid, 1);
      check_model("tbl_model");
    end

    // Reset in the middle of a restore, after two writes.
    set_mapper(32'h0);
    restore_req = 1'b1;
    @(posedge clk); #1;
    restore_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_reset_strobe", hypervisor_load_user_reg, 1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_strobe", hypervisor_load_user_reg, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_valid", shadow_valid, 0);
    read_shadow(rd);
    check("mid_reset_shadow", rd, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) sh_m[i] = 8'h00;
    sv_m = 1'b0;
    set_mapper(32'h0C1D2E3F);
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 0, 0, 0, e, ab);
    check("post_reset_end", e, 5);
    read_shadow(rd);
    check("post_reset_shadow", rd, 32'h0C1D2E3F);
    check_model("post_reset");

    // Randomized operations against the reference model.
    for (int it = 0; it < 24; it++) begin
      int r;
      r = $urandom_range(0, 3);
      set_mapper($urandom);
      if (r == 2) hyp_write(2'($urandom_range(0, 3)), 8'($urandom));
      run_op(r == 0 || r == 3, r != 0, $urandom_range(1, 5), $urandom_range(0, 5),
             (r == 3) ? 2 : 0, e, ab);
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mapper_ctx_engine.md
Name: mapper_ctx_engine

Overview:
Hypervisor-side save/restore engine for the 4510 user mapper registers (A, X, Y, Z of map 0). It drives the mapper's register read-select interface and its hypervisor write interface (write select, write data, load strobe). On a save it snapshots the live mapper state into a 4-entry shadow file. On a restore it writes the shadow file back, stalling while a MAP instruction is in flight. Sits between the hypervisor trap controller and the mapper / MAP sequencer.

Parameters:
STALL_MAX, 255, max consecutive cycles a restore write may stall on map_active before aborting (1..65535)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
save_req  input  1  single-cycle pulse: snapshot mapper regs into shadow
restore_req  input  1  single-cycle pulse: write shadow into mapper regs
busy  output  1  high from acceptance until the cycle after completion
done  output  1  one-cycle pulse when a save or restore completes
abort  output  1  one-cycle pulse when a restore times out on map_active
shadow_valid  output  1  high once a save has completed; cleared only by reset
map_reg_sel  output  2  read select into mapper: 3=A, 2=X, 1=Y, 0=Z
map_reg_data  input  8  mapper register read data, combinational from map_reg_sel
map_reg_write_sel  output  2  write select: 3=A, 2=X, 1=Y, 0=Z
map_reg_wdata  output  8  write data for the mapper
hypervisor_load_user_reg  output  1  one-cycle write strobe to the mapper
map_active  input  1  mapper's MAP-in-progress flag; writes forbidden while high
sel_override  output  1  high while the engine owns the mapper read select (equals the SAVE state)
shadow_idx  input  2  hypervisor access index into the shadow file
shadow_we  input  1  hypervisor shadow write enable
shadow_wdata  input  8  hypervisor shadow write data
shadow_rdata  output  8  shadow[shadow_idx], combinational

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; all outputs 0; map_reg_sel = 3.
  - Shadow entries 0x00; shadow_valid = 0; stall counter 0.
- State machine: IDLE, SAVE, RST_WR, FINISH. A 2-bit index idx counts 3 down to 0 (order A, X, Y, Z).
- IDLE:
  - save_req → SAVE with idx = 3.
  - restore_req (save_req low) → RST_WR with idx = 3.
  - Both asserted in the same cycle: save wins and restore_req is dropped.
  - Requests in any other state are ignored; no queuing.
- SAVE:
  - map_reg_sel = idx and sel_override = 1.
  - At each rising edge, shadow[idx] <= map_reg_data and idx decrements.
  - After idx 0 → FINISH. Exactly 4 cycles.
  - Saves never stall on map_active; reads are always legal.
- RST_WR, map_active = 0:
  - hypervisor_load_user_reg = 1, map_reg_write_sel = idx, map_reg_wdata = shadow[idx].
  - Stall counter clears; idx decrements. After idx 0 → FINISH.
- RST_WR, map_active = 1:
  - Strobe low and idx held; stall counter increments.
  - If the counter reaches STALL_MAX, pulse abort and return to IDLE. No done pulse; writes already issued are not undone.
- Strobe timing: hypervisor_load_user_reg is registered-free combinational from state, idx and map_active, so the mapper sees it in the same cycle. It never asserts while map_active is high.
- FINISH:
  - done = 1 for one cycle; busy still high.
  - If the operation was a save, set shadow_valid.
  - → IDLE.
- busy = (state != IDLE).
- Latency with no stall: request at edge N; data cycles N+1..N+4; done in cycle N+5; busy low from N+6.
- Shadow hypervisor writes:
  - Honoured only when busy = 0; ignored while busy.
  - shadow_rdata is always live, including during an operation.
- Restore with shadow_valid = 0 is allowed and writes the reset values (0x00).
- Reset mid-operation: immediate return to IDLE, strobe drops asynchronously, shadow cleared.

Decomposition:
- Shared package:
  - Register index constants MAPREG_A = 3, MAPREG_X = 2, MAPREG_Y = 1, MAPREG_Z = 0 (also used by the mapper FSM and the hypervisor register decode).
  - State encoding for IDLE / SAVE / RST_WR / FINISH.
- One natural sub-module: mapper_ctx_shadow, the 4x8 register file with async active-low reset, one write port (engine capture has priority; hypervisor write gated by !busy) and two read ports (engine idx, hypervisor shadow_idx).

Test Plan:
- Save: mapper A=0x40, X=0x31, Y=0x00, Z=0x3F; pulse save_req → map_reg_sel 3,2,1,0 on consecutive cycles; shadow = {40,31,00,3F}; done pulse at N+5; shadow_valid = 1.
- Restore: hypervisor writes shadow[2] = 0x8A, then pulses restore_req → four strobes with (sel, data) = (3,40), (2,8A), (1,00), (0,3F); done pulse at N+5.
- Stall: map_active high for 3 cycles after the first restore write → strobe low during those cycles; sequence resumes at X; done at N+8.
- Timeout with STALL_MAX = 4 and map_active held high → abort pulse after exactly 4 stall cycles; no done; busy low the next cycle.
- Simultaneous save_req and restore_req in IDLE → save sequence runs and no write strobes occur; a restore_req while busy is ignored.
- Reset: reset_n low mid-restore after 2 writes → strobe low immediately; state IDLE; shadow = 0; shadow_valid = 0; subsequent save works normally.
